// File: rtl/m_ptw_mem_responder_pkg.sv
// Shared state encodings, default address window and range-check helper
// for the page-table walker's PTE memory responder.
package m_ptw_mem_responder_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HIT   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [31:0] DEF_MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_MEM_SIZE = 32'h0800_0000;
    localparam int          DEF_TIMEOUT  = 1024;

    // The upper bound is formed in 33 bits so a window ending at 4 GiB cannot wrap.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
        logic [32:0] w_lim;
        w_lim = {1'b0, base} + {1'b0, size};
        return (addr[1:0] == 2'b00) &&
               ({1'b0, addr} >= {1'b0, base}) &&
               ({1'b0, addr} < w_lim);
    endfunction

endpackage

// File: rtl/m_ptw_mem_responder_pte_buf.sv
// One-entry PTE buffer: tag, data and valid bit with flush and fill ports
// and a combinational hit output for the lookup address.
module m_pte_buf (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_flush,
    input  logic        i_fill,
    input  logic [31:0] i_fill_addr,
    input  logic [31:0] i_fill_data,
    input  logic [31:0] i_lookup_addr,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [31:0] r_tag;
    logic [31:0] r_data;

    // Flush takes priority so a fill racing an invalidation never survives it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_tag   <= 32'h0;
            r_data  <= 32'h0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_addr;
            r_data  <= i_fill_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_addr);
    assign o_data = r_data;

endmodule

// File: rtl/m_ptw_mem_responder.sv
// PTE port responder: range/alignment check, one-entry PTE buffer, and a
// DRAM request/response sequencer presenting a busy/rdata contract to the walker.
module m_ptw_mem_responder
    import m_ptw_mem_responder_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = DEF_MEM_BASE,
    parameter logic [31:0] MEM_SIZE = DEF_MEM_SIZE,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_busy,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_dram_req,
    output logic        o_dram_we,
    output logic [31:0] o_dram_addr,
    output logic [31:0] o_dram_wdata,
    input  logic        i_dram_ready,
    input  logic        i_dram_valid,
    input  logic [31:0] i_dram_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         r_state;
    logic           r_busy;
    logic           r_fault;
    logic [31:0]    r_rdata;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic           r_nofill;
    logic [CW-1:0]  r_cnt;
    logic           r_dram_req;
    logic           r_dram_we;
    logic [31:0]    r_dram_addr;
    logic [31:0]    r_dram_wdata;

    logic           w_addr_ok;
    logic           w_buf_hit;
    logic [31:0]    w_buf_data;
    logic           w_fill;
    logic [31:0]    w_fill_data;

    assign w_addr_ok   = addr_ok(i_addr, MEM_BASE, MEM_SIZE);
    assign w_fill      = (r_state == S_WAIT) && i_dram_valid && !r_nofill && !i_flush;
    assign w_fill_data = r_we ? r_wdata : i_dram_rdata;

    m_pte_buf u_pte_buf (
        .CLK           (CLK),
        .RST           (RST),
        .i_flush       (i_flush),
        .i_fill        (w_fill),
        .i_fill_addr   (r_addr),
        .i_fill_data   (w_fill_data),
        .i_lookup_addr (i_addr),
        .o_hit         (w_buf_hit),
        .o_data        (w_buf_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_rdata      <= 32'h0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_nofill     <= 1'b0;
            r_cnt        <= '0;
            r_dram_req   <= 1'b0;
            r_dram_we    <= 1'b0;
            r_dram_addr  <= 32'h0;
            r_dram_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_we     <= i_we;
                        r_addr   <= i_addr;
                        r_wdata  <= i_wdata;
                        r_fault  <= 1'b0;
                        r_rdata  <= 32'h0;
                        r_nofill <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        // A flush arriving with the read forces the DRAM path.
                        if (!w_addr_ok) begin
                            r_state <= S_FAULT;
                        end else if (!i_we && w_buf_hit && !i_flush) begin
                            r_state <= S_HIT;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_dram_req   <= 1'b1;
                            r_dram_we    <= i_we;
                            r_dram_addr  <= i_addr;
                            r_dram_wdata <= i_wdata;
                        end
                    end
                end
                S_FAULT: begin
                    r_fault <= 1'b1;
                    r_rdata <= 32'h0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_HIT: begin
                    r_rdata <= w_buf_data;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ISSUE: begin
                    if (i_flush) r_nofill <= 1'b1;
                    if (i_dram_ready) begin
                        r_dram_req   <= 1'b0;
                        r_dram_we    <= 1'b0;
                        r_dram_addr  <= 32'h0;
                        r_dram_wdata <= 32'h0;
                        r_cnt        <= '0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_flush) r_nofill <= 1'b1;
                    if (i_dram_valid) begin
                        if (!r_we) r_rdata <= i_dram_rdata;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_fault <= 1'b1;
                        r_rdata <= 32'h0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_rdata      = r_rdata;
    assign o_fault      = r_fault;
    assign o_dram_req   = r_dram_req;
    assign o_dram_we    = r_dram_we;
    assign o_dram_addr  = r_dram_addr;
    assign o_dram_wdata = r_dram_wdata;

endmodule

// File: tb/tb_m_ptw_mem_responder.sv
// Directed self-checking bench for m_ptw_mem_responder; a cycle-stepped DRAM
// stub inside runTxn answers with programmable ready/valid delays.
module tb_m_ptw_mem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_req = 1'b0, i_we = 1'b0, i_flush = 1'b0;
    logic [31:0] i_addr = 32'h0, i_wdata = 32'h0;
    logic        o_busy, o_fault, o_dram_req, o_dram_we;
    logic [31:0] o_rdata, o_dram_addr, o_dram_wdata;
    logic        i_dram_ready = 1'b0, i_dram_valid = 1'b0;
    logic [31:0] i_dram_rdata = 32'h0;

    int nCompared = 0;
    int nMismatched = 0;

    int gBusy, gHs, gReqCycles, gWait, gAddrBad;
    logic        gWe;
    logic [31:0] gWdata;
    logic        holdReq = 1'b0;
    logic        flushOnAccept = 1'b0;

    always #5 CLK = ~CLK;

    m_ptw_mem_responder #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_flush(i_flush),
        .o_busy(o_busy), .o_rdata(o_rdata), .o_fault(o_fault),
        .o_dram_req(o_dram_req), .o_dram_we(o_dram_we),
        .o_dram_addr(o_dram_addr), .o_dram_wdata(o_dram_wdata),
        .i_dram_ready(i_dram_ready), .i_dram_valid(i_dram_valid), .i_dram_rdata(i_dram_rdata)
    );

    // Issue one request and play the DRAM side cycle by cycle until busy falls.
    task automatic runTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int readyDelay, input int validDelay,
                          input logic [31:0] rdata, input logic respond, input int flushAt);
        logic hs;
        hs = 1'b0;
        gBusy = 0; gHs = 0; gReqCycles = 0; gWait = 0; gAddrBad = 0;
        gWe = 1'b0; gWdata = 32'h0;
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_flush = flushOnAccept;
        @(negedge CLK);
        i_req = holdReq; i_flush = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!o_busy) break;
            gBusy++;
            i_dram_ready = 1'b0; i_dram_valid = 1'b0;
            i_flush = ((gBusy - 1) == flushAt);
            if (o_dram_req) begin
                if (o_dram_addr !== addr) gAddrBad++;
                if (gReqCycles == readyDelay) begin
                    i_dram_ready = 1'b1; gHs++; gWe = o_dram_we; gWdata = o_dram_wdata; hs = 1'b1;
                end
                gReqCycles++;
            end else if (hs) begin
                gWait++;
                if (respond && (gWait - 1) == validDelay) begin
                    i_dram_valid = 1'b1; i_dram_rdata = rdata;
                end
            end
            @(negedge CLK);
        end
        i_req = 1'b0; i_flush = 1'b0; i_dram_ready = 1'b0; i_dram_valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        nCompared++;
        if ({o_busy, o_fault, o_dram_req, o_dram_we} !== 4'b0) begin
            nMismatched++; $display("[TB] FAIL reset_flags: got %b want 0000", {o_busy, o_fault, o_dram_req, o_dram_we});
        end
        nCompared++;
        if ({o_rdata, o_dram_addr, o_dram_wdata} !== 96'h0) begin
            nMismatched++; $display("[TB] FAIL reset_data: got %h/%h/%h want 0", o_rdata, o_dram_addr, o_dram_wdata);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_read_miss;
        runTxn(1'b0, 32'h0010_0008, 32'h0, 0, 3, 32'h2000_04CF, 1'b1, -1);
        nCompared++;
        if (gBusy != 5) begin nMismatched++; $display("[TB] FAIL miss_busy: got %0d want 5", gBusy); end
        nCompared++;
        if (o_rdata !== 32'h2000_04CF) begin nMismatched++; $display("[TB] FAIL miss_rdata: got %h want 200004cf", o_rdata); end
        nCompared++;
        if (o_fault !== 1'b0) begin nMismatched++; $display("[TB] FAIL miss_fault: got %b want 0", o_fault); end
        nCompared++;
        if (gHs != 1 || gAddrBad != 0 || gWe !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL miss_handshake: got hs=%0d addrbad=%0d we=%b want 1/0/0", gHs, gAddrBad, gWe);
        end
    endtask

    task automatic test_read_hit;
        holdReq = 1'b1;
        runTxn(1'b0, 32'h0010_0008, 32'h0, 0, 0, 32'hBAD0_BAD0, 1'b1, -1);
        holdReq = 1'b0;
        nCompared++;
        if (gBusy != 1 || gReqCycles != 0) begin
            nMismatched++; $display("[TB] FAIL hit_busy: got busy=%0d req=%0d want 1/0", gBusy, gReqCycles);
        end
        nCompared++;
        if (o_rdata !== 32'h2000_04CF) begin nMismatched++; $display("[TB] FAIL hit_rdata: got %h want 200004cf", o_rdata); end
        @(negedge CLK);
        nCompared++;
        if (o_busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL hit_no_requeue: got busy=%b want 0", o_busy); end
    endtask

    task automatic test_write_ad;
        runTxn(1'b1, 32'h0010_0008, 32'h2000_04CF | 32'h0000_00C0, 0, 1, 32'hDEAD_BEEF, 1'b1, -1);
        nCompared++;
        if (gHs != 1 || gWe !== 1'b1 || gWdata !== 32'h2000_04CF) begin
            nMismatched++; $display("[TB] FAIL write_issue: got hs=%0d we=%b wdata=%h want 1/1/200004cf", gHs, gWe, gWdata);
        end
        nCompared++;
        if (gBusy != 3 || o_rdata !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL write_done: got busy=%0d rdata=%h want 3/0", gBusy, o_rdata);
        end
        runTxn(1'b0, 32'h0010_0008, 32'h0, 0, 0, 32'hBAD0_BAD0, 1'b1, -1);
        nCompared++;
        if (gBusy != 1 || gReqCycles != 0 || o_rdata !== 32'h2000_04CF) begin
            nMismatched++; $display("[TB] FAIL write_readback: got busy=%0d req=%0d rdata=%h want 1/0/200004cf", gBusy, gReqCycles, o_rdata);
        end
        runTxn(1'b1, 32'h0010_0008, 32'h2000_0401 | 32'h0000_00C0, 2, 0, 32'hDEAD_BEEF, 1'b1, -1);
        nCompared++;
        if (gReqCycles != 3 || gAddrBad != 0 || gWdata !== 32'h2000_04C1) begin
            nMismatched++; $display("[TB] FAIL write_stall: got req=%0d addrbad=%0d wdata=%h want 3/0/200004c1", gReqCycles, gAddrBad, gWdata);
        end
        runTxn(1'b0, 32'h0010_0008, 32'h0, 0, 0, 32'hBAD0_BAD0, 1'b1, -1);
        nCompared++;
        if (gBusy != 1 || o_rdata !== 32'h2000_04C1) begin
            nMismatched++; $display("[TB] FAIL write_fill: got busy=%0d rdata=%h want 1/200004c1", gBusy, o_rdata);
        end
    endtask

    task automatic test_fault;
        runTxn(1'b0, 32'h0800_0000, 32'h0, 0, 0, 32'h1111_1111, 1'b1, -1);
        nCompared++;
        if (gBusy != 1 || gReqCycles != 0 || o_fault !== 1'b1 || o_rdata !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL fault_range: got busy=%0d req=%0d fault=%b rdata=%h want 1/0/1/0", gBusy, gReqCycles, o_fault, o_rdata);
        end
        runTxn(1'b0, 32'h0010_0002, 32'h0, 0, 0, 32'h1111_1111, 1'b1, -1);
        nCompared++;
        if (gBusy != 1 || gReqCycles != 0 || o_fault !== 1'b1 || o_rdata !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL fault_align: got busy=%0d req=%0d fault=%b rdata=%h want 1/0/1/0", gBusy, gReqCycles, o_fault, o_rdata);
        end
        runTxn(1'b0, 32'h07FF_FFFC, 32'h0, 0, 0, 32'h0000_0A5F, 1'b1, -1);
        nCompared++;
        if (gBusy != 2 || gHs != 1 || o_fault !== 1'b0 || o_rdata !== 32'h0000_0A5F) begin
            nMismatched++; $display("[TB] FAIL fault_top_edge: got busy=%0d hs=%0d fault=%b rdata=%h want 2/1/0/00000a5f", gBusy, gHs, o_fault, o_rdata);
        end
    endtask

    task automatic test_flush;
        runTxn(1'b0, 32'h0000_2000, 32'h0, 0, 3, 32'h0000_2C01, 1'b1, 2);
        nCompared++;
        if (gBusy != 5 || o_rdata !== 32'h0000_2C01) begin
            nMismatched++; $display("[TB] FAIL flush_wait_read: got busy=%0d rdata=%h want 5/00002c01", gBusy, o_rdata);
        end
        runTxn(1'b0, 32'h0000_2000, 32'h0, 0, 0, 32'h0000_2C02, 1'b1, -1);
        nCompared++;
        if (gHs != 1 || o_rdata !== 32'h0000_2C02) begin
            nMismatched++; $display("[TB] FAIL flush_reread_miss: got hs=%0d rdata=%h want 1/00002c02", gHs, o_rdata);
        end
        flushOnAccept = 1'b1;
        runTxn(1'b0, 32'h0000_2000, 32'h0, 0, 0, 32'h0000_2C03, 1'b1, -1);
        flushOnAccept = 1'b0;
        nCompared++;
        if (gHs != 1 || o_rdata !== 32'h0000_2C03) begin
            nMismatched++; $display("[TB] FAIL flush_on_accept: got hs=%0d rdata=%h want 1/00002c03", gHs, o_rdata);
        end
        runTxn(1'b0, 32'h0000_2000, 32'h0, 0, 0, 32'hBAD0_BAD0, 1'b1, -1);
        nCompared++;
        if (gBusy != 1 || o_rdata !== 32'h0000_2C03) begin
            nMismatched++; $display("[TB] FAIL flush_accept_fills: got busy=%0d rdata=%h want 1/00002c03", gBusy, o_rdata);
        end
    endtask

    task automatic test_timeout;
        runTxn(1'b0, 32'h0000_3000, 32'h0, 0, 0, 32'h0, 1'b0, -1);
        nCompared++;
        if (gWait != 8 || gBusy != 9) begin
            nMismatched++; $display("[TB] FAIL timeout_cycles: got wait=%0d busy=%0d want 8/9", gWait, gBusy);
        end
        nCompared++;
        if (o_fault !== 1'b1 || o_rdata !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL timeout_fault: got fault=%b rdata=%h want 1/0", o_fault, o_rdata);
        end
        runTxn(1'b0, 32'h0000_3000, 32'h0, 0, 0, 32'h0000_3C01, 1'b1, -1);
        nCompared++;
        if (gHs != 1 || o_fault !== 1'b0 || o_rdata !== 32'h0000_3C01) begin
            nMismatched++; $display("[TB] FAIL timeout_no_fill: got hs=%0d fault=%b rdata=%h want 1/0/00003c01", gHs, o_fault, o_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int stableBad;
        stableBad = 0;
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_4000;
        @(negedge CLK);
        i_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (o_dram_req !== 1'b1 || o_dram_addr !== 32'h0000_4000) stableBad++;
            @(negedge CLK);
        end
        nCompared++;
        if (stableBad != 0) begin nMismatched++; $display("[TB] FAIL stall_stable: got %0d bad cycles want 0", stableBad); end
        i_dram_ready = 1'b1;
        @(negedge CLK);
        i_dram_ready = 1'b0;
        repeat (2) @(negedge CLK);
        nCompared++;
        if (o_busy !== 1'b1 || o_dram_req !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL mid_in_wait: got busy=%b req=%b want 1/0", o_busy, o_dram_req);
        end
        RST = 1'b1;
        #1;
        nCompared++;
        if ({o_busy, o_fault, o_dram_req, o_dram_we, o_rdata, o_dram_addr, o_dram_wdata} !== 100'h0) begin
            nMismatched++; $display("[TB] FAIL mid_reset_outputs: got busy=%b fault=%b req=%b rdata=%h want all 0", o_busy, o_fault, o_dram_req, o_rdata);
        end
        @(negedge CLK);
        RST = 1'b0;
        i_dram_valid = 1'b1; i_dram_rdata = 32'h5555_AAAA;
        @(negedge CLK);
        i_dram_valid = 1'b0;
        @(negedge CLK);
        nCompared++;
        if (o_busy !== 1'b0 || o_rdata !== 32'h0 || o_fault !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL stray_valid: got busy=%b rdata=%h fault=%b want 0/0/0", o_busy, o_rdata, o_fault);
        end
        runTxn(1'b0, 32'h0000_2000, 32'h0, 0, 0, 32'h0000_2C04, 1'b1, -1);
        nCompared++;
        if (gHs != 1 || o_rdata !== 32'h0000_2C04) begin
            nMismatched++; $display("[TB] FAIL reset_clears_buf: got hs=%0d rdata=%h want 1/00002c04", gHs, o_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_ad();
        test_fault();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
